n64adv2_vdemux: RTL

N64ADV2_VDEMUX -- requirements
Module: n64adv2_vdemux

---
 rtl/n64adv2_vdemux.sv | 117 +++++++++++
 1 files changed

// File: rtl/n64adv2_vdemux.sv
// N64 video bus demultiplexer: splits the 4-word {sync,R,G,B} stream into
// parallel pixels and derives line count, PAL and interlace flags from sync.
module n64adv2_vdemux #(
  parameter int         color_width_i = 7,
  parameter logic [9:0] pal_thresh    = 10'd287
) (
  input  logic                         N64_CLK_i,
  input  logic                         N64_nVRST_i,
  input  logic                         nVDSYNC_i,
  input  logic [color_width_i-1:0]     VD_i,
  output logic                         pxl_valid_o,
  output logic [3:0]                   sync_o,
  output logic [3*color_width_i-1:0]   rgb_o,
  output logic [9:0]                   line_cnt_o,
  output logic                         pal_o,
  output logic                         interlaced_o,
  output logic                         resync_o
);

  typedef enum logic [1:0] {IDLE, RED, GREEN, BLUE} state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic                       w_cap_sync;
  logic                       w_cap_r;
  logic                       w_cap_g;
  logic                       w_emit;
  logic                       w_abort;
  logic                       w_line_edge;
  logic                       w_field_edge;
  logic                       w_diff_one;
  logic [10:0]                w_cnt_ext;
  logic [10:0]                w_last_ext;

  logic [3:0]                 r_sync_sh;
  logic [color_width_i-1:0]   r_red;
  logic [color_width_i-1:0]   r_grn;
  logic [9:0]                 r_last_lines;

  always_ff @(posedge N64_CLK_i or negedge N64_nVRST_i) begin
    if (!N64_nVRST_i) r_state <= IDLE;
    else              r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cap_sync  = 1'b0;
    w_cap_r     = 1'b0;
    w_cap_g     = 1'b0;
    w_emit      = 1'b0;
    w_abort     = 1'b0;
    if (!nVDSYNC_i) begin
      w_cap_sync  = 1'b1;
      w_abort     = (r_state != IDLE);
      w_state_nxt = RED;
    end else begin
      case (r_state)
        RED:   begin w_cap_r = 1'b1; w_state_nxt = GREEN; end
        GREEN: begin w_cap_g = 1'b1; w_state_nxt = BLUE;  end
        BLUE:  begin w_emit  = 1'b1; w_state_nxt = IDLE;  end
        default: ;
      endcase
    end
  end

  // Edges are falling transitions of the active-low VSYNC#/HSYNC# bits
  // between consecutive captured sync words.
  assign w_line_edge  = w_cap_sync & ~VD_i[1] & r_sync_sh[1];
  assign w_field_edge = w_cap_sync & ~VD_i[3] & r_sync_sh[3];

  // Widened by one bit so 1023 + 1 does not wrap back to 0.
  assign w_cnt_ext  = {1'b0, line_cnt_o};
  assign w_last_ext = {1'b0, r_last_lines};
  assign w_diff_one = (w_cnt_ext == w_last_ext + 11'd1) ||
                      (w_last_ext == w_cnt_ext + 11'd1);

  always_ff @(posedge N64_CLK_i) begin
    if (w_cap_r) r_red <= VD_i;
    if (w_cap_g) r_grn <= VD_i;
  end

  always_ff @(posedge N64_CLK_i or negedge N64_nVRST_i) begin
    if (!N64_nVRST_i) begin
      r_sync_sh   <= 4'hF;
      pxl_valid_o <= 1'b0;
      resync_o    <= 1'b0;
      sync_o      <= 4'hF;
      rgb_o       <= '0;
    end else begin
      pxl_valid_o <= w_emit;
      resync_o    <= w_abort;
      if (w_cap_sync) r_sync_sh <= VD_i[3:0];
      // Blue is taken straight from the bus on the cycle that completes the pixel.
      if (w_emit) begin
        sync_o <= r_sync_sh;
        rgb_o  <= {r_red, r_grn, VD_i};
      end
    end
  end

  always_ff @(posedge N64_CLK_i or negedge N64_nVRST_i) begin
    if (!N64_nVRST_i) begin
      line_cnt_o   <= 10'd0;
      r_last_lines <= 10'd0;
      pal_o        <= 1'b0;
      interlaced_o <= 1'b0;
    end else if (w_field_edge) begin
      line_cnt_o   <= 10'd0;
      r_last_lines <= line_cnt_o;
      pal_o        <= (line_cnt_o > pal_thresh);
      interlaced_o <= w_diff_one;
    end else if (w_line_edge && (line_cnt_o != 10'd1023)) begin
      line_cnt_o <= line_cnt_o + 10'd1;
    end
  end

endmodule
